data_cache_line_allocator: RTL and testbench

//  Refill engine on the write side of a data cache way. On a miss it accepts one cache

---
 rtl/data_memory_pkg.sv | 22 ++
 rtl/data_cache_line_allocator.sv | 109 ++++++++++
 tb/tb_data_cache_line_allocator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared data cache port types and the line allocator state encoding.
package data_memory_pkg;
    localparam int TAG_SIZE    = 20;
    localparam int BLOCK_WORDS = 4;
    localparam int PORT_BYTES  = 4;

    typedef struct packed {
        logic valid;
        logic dirty;
        logic tag;
        logic data;
    } data_cache_enable_t;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_SIZE-1:0] tag;
        logic [31:0]         word;
    } data_cache_packet_t;

    typedef enum logic [1:0] {IDLE, FILL, FINALIZE} allocator_fsm_t;
endpackage

// File: rtl/data_cache_line_allocator.sv
// data_cache_line_allocator: refills one cache block from the memory bus into a way via port 0.
module data_cache_line_allocator
    import data_memory_pkg::data_cache_enable_t;
    import data_memory_pkg::data_cache_packet_t;
    import data_memory_pkg::allocator_fsm_t;
    import data_memory_pkg::PORT_BYTES;
    import data_memory_pkg::IDLE;
    import data_memory_pkg::FILL;
    import data_memory_pkg::FINALIZE;
#(
    parameter int WAY_NUMBER  = 2,
    parameter int BLOCK_WORDS = data_memory_pkg::BLOCK_WORDS,
    parameter int ADDR_WIDTH  = 7,
    parameter int TAG_SIZE    = data_memory_pkg::TAG_SIZE,
    localparam int CHIP_ADDR  = $clog2(BLOCK_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  allocate_i,
    input  logic [ADDR_WIDTH-1:0] allocate_address_i,
    input  logic [TAG_SIZE-1:0]   allocate_tag_i,
    input  logic [WAY_NUMBER-1:0] allocate_way_i,
    output logic                  allocate_ready_o,
    input  logic [31:0]           mem_word_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    output logic [WAY_NUMBER-1:0] way_enable_o,
    output data_cache_enable_t    port0_enable_o,
    output logic [CHIP_ADDR-1:0]  port0_chip_select_o,
    output logic [PORT_BYTES-1:0] port0_byte_write_o,
    output logic [ADDR_WIDTH-1:0] port0_address_o,
    output data_cache_packet_t    port0_cache_packet_o,
    output logic                  port0_write_o,
    output logic                  done_o
);
    allocator_fsm_t        state_q, state_d;
    logic [CHIP_ADDR-1:0]  cnt_q, cnt_d, chip_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TAG_SIZE-1:0]   tag_q;
    logic [WAY_NUMBER-1:0] way_q;
    logic [31:0]           word_q;
    logic                  wr_q, first_q;
    logic                  start, accept, last_beat, fin;

    assign start     = state_q == IDLE && allocate_i;
    assign accept    = state_q == FILL && mem_valid_i;
    assign last_beat = cnt_q == CHIP_ADDR'(BLOCK_WORDS - 1);
    assign fin       = state_q == FINALIZE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chip_q  <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
            way_q   <= '0;
            word_q  <= '0;
            wr_q    <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= accept;
            if (start) begin
                addr_q <= allocate_address_i;
                tag_q  <= allocate_tag_i;
                way_q  <= allocate_way_i;
            end
            if (accept) begin
                chip_q  <= cnt_q;
                word_q  <= mem_word_i;
                first_q <= cnt_q == '0;
            end
        end
    end

    // The first word clears valid so a half-filled line can never hit; the last sets it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = FILL;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = last_beat ? FINALIZE : FILL;
        end else if (fin) begin
            state_d = IDLE;
        end
        allocate_ready_o           = state_q == IDLE;
        mem_ready_o                = state_q == FILL;
        done_o                     = fin;
        port0_write_o              = wr_q;
        way_enable_o               = wr_q ? way_q : '0;
        port0_chip_select_o        = wr_q ? chip_q : '0;
        port0_byte_write_o         = {PORT_BYTES{wr_q}};
        port0_address_o            = state_q != IDLE ? addr_q : '0;
        port0_enable_o             = '0;
        port0_enable_o.valid       = wr_q & (first_q | fin);
        port0_enable_o.dirty       = wr_q & fin;
        port0_enable_o.tag         = wr_q & fin;
        port0_enable_o.data        = wr_q;
        port0_cache_packet_o       = '0;
        port0_cache_packet_o.valid = fin;
        port0_cache_packet_o.tag   = fin ? tag_q : '0;
        port0_cache_packet_o.word  = wr_q ? word_q : '0;
    end
endmodule

// File: tb/tb_data_cache_line_allocator.sv
// tb_data_cache_line_allocator: directed and random refills checked against a beat-level model.
module tb_data_cache_line_allocator;
    import data_memory_pkg::*;

    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        allocate_i = 1'b0;
    logic [6:0]  allocate_address_i = '0;
    logic [19:0] allocate_tag_i = '0;
    logic [1:0]  allocate_way_i = '0;
    logic [31:0] mem_word_i = '0;
    logic        mem_valid_i = 1'b0;
    logic        allocate_ready_o, mem_ready_o, port0_write_o, done_o;
    logic [1:0]  way_enable_o;
    data_cache_enable_t port0_enable_o;
    logic [1:0]  port0_chip_select_o;
    logic [3:0]  port0_byte_write_o;
    logic [6:0]  port0_address_o;
    data_cache_packet_t port0_cache_packet_o;

    int total = 0;
    int bad = 0;

    // Model: phase 0 idle, 1 receiving beats, 2 closing; pending = beat taken last cycle.
    int          m_ph = 0;
    int          m_beats = 0;
    logic [6:0]  m_addr = '0;
    logic [19:0] m_tag = '0;
    logic [1:0]  m_way = '0;
    logic        m_pend = 1'b0;
    int          m_pk = 0;
    logic [31:0] m_pw = '0;

    always #5 clk = ~clk;

    data_cache_line_allocator dut (
        .clk_i(clk), .rst_i(rst_i),
        .allocate_i(allocate_i), .allocate_address_i(allocate_address_i),
        .allocate_tag_i(allocate_tag_i), .allocate_way_i(allocate_way_i),
        .allocate_ready_o(allocate_ready_o),
        .mem_word_i(mem_word_i), .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .way_enable_o(way_enable_o), .port0_enable_o(port0_enable_o),
        .port0_chip_select_o(port0_chip_select_o), .port0_byte_write_o(port0_byte_write_o),
        .port0_address_o(port0_address_o), .port0_cache_packet_o(port0_cache_packet_o),
        .port0_write_o(port0_write_o), .done_o(done_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_beats = 0; m_pend = 1'b0;
        m_addr = '0; m_tag = '0; m_way = '0;
    endtask

    task automatic check_outputs();
        logic last, first;
        last  = m_pend && m_pk == BW - 1;
        first = m_pend && m_pk == 0;
        chk("ready", 64'(allocate_ready_o), 64'(m_ph == 0));
        chk("mem_ready", 64'(mem_ready_o), 64'(m_ph == 1));
        chk("done", 64'(done_o), 64'(m_ph == 2));
        chk("write", 64'(port0_write_o), 64'(m_pend));
        chk("way_en", 64'(way_enable_o), 64'(m_pend ? m_way : 2'b00));
        chk("enable", 64'(port0_enable_o), 64'({first | last, last, last, m_pend}));
        chk("chip", 64'(port0_chip_select_o), 64'(m_pend ? 2'(m_pk) : 2'b00));
        chk("bytes", 64'(port0_byte_write_o), 64'(m_pend ? 4'hF : 4'h0));
        chk("addr", 64'(port0_address_o), 64'(m_ph != 0 ? m_addr : 7'h0));
        chk("packet", 64'(port0_cache_packet_o),
            64'({last, 1'b0, last ? m_tag : 20'h0, m_pend ? m_pw : 32'h0}));
    endtask

    task automatic model_edge();
        logic take;
        take   = m_ph == 1 && mem_valid_i;
        m_pend = take;
        if (take) begin
            m_pk = m_beats;
            m_pw = mem_word_i;
        end
        if (m_ph == 0 && allocate_i) begin
            m_ph = 1; m_beats = 0;
            m_addr = allocate_address_i; m_tag = allocate_tag_i; m_way = allocate_way_i;
        end else if (take) begin
            m_beats++;
            if (m_beats == BW) m_ph = 2;
        end else if (m_ph == 2) begin
            m_ph = 0;
        end
    endtask

    task automatic cyc(input logic al, input logic [6:0] ad, input logic [19:0] tg,
                       input logic [1:0] wy, input logic v, input logic [31:0] w);
        allocate_i = al; allocate_address_i = ad; allocate_tag_i = tg; allocate_way_i = wy;
        mem_valid_i = v; mem_word_i = w;
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic [31:0] base, input logic [6:0] pattern, input int n,
                         input logic al);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            cyc(al, 7'h15, 20'hABCDE, 2'b10, pattern[i], base + 32'(k));
            if (pattern[i]) k++;
        end
    endtask

    task automatic refill_random(input int pct);
        logic [1:0] wy;
        int budget = 200;
        wy = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        cyc(1'b1, 7'($urandom), 20'($urandom), wy, 1'($urandom), $urandom);
        while (m_ph != 0 && budget > 0) begin
            cyc(1'($urandom_range(0, 3) == 0), 7'($urandom), 20'($urandom),
                2'($urandom), $urandom_range(0, 99) < pct, $urandom);
            budget--;
        end
        if (budget == 0) chk("refill_timeout", 64'(m_ph), 64'(0));
    endtask

    initial begin
        #2;
        chk("rst_ready", 64'(allocate_ready_o), 64'(1));
        chk("rst_write", 64'(port0_write_o), 64'(0));
        chk("rst_addr", 64'(port0_address_o), 64'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        // back-to-back fill
        cyc(1'b1, 7'h15, 20'hABCDE, 2'b10, 1'b0, 32'h0);
        beats(32'hA0A0_0000, 7'b0001111, 7, 1'b0);
        // gapped beats 1,0,0,1,1,0,1
        cyc(1'b1, 7'h15, 20'hABCDE, 2'b10, 1'b0, 32'h0);
        beats(32'hB0B0_0000, 7'b1011001, 9, 1'b0);
        // request held high across a refill and past done
        cyc(1'b1, 7'h15, 20'hABCDE, 2'b10, 1'b0, 32'h0);
        beats(32'hC0C0_0000, 7'b1111111, 7, 1'b1);
        beats(32'hC1C1_0000, 7'b1111111, 4, 1'b0);
        // beats offered while idle are ignored
        for (int i = 0; i < 3; i++) cyc(1'b0, 7'h0, 20'h0, 2'b00, 1'b1, 32'hDEAD_0000 + 32'(i));
        // asynchronous reset after two beats
        cyc(1'b1, 7'h15, 20'hABCDE, 2'b10, 1'b0, 32'h0);
        beats(32'hE0E0_0000, 7'b0000011, 3, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 7'h15, 20'hABCDE, 2'b10, 1'b0, 32'h0);
        beats(32'hF0F0_0000, 7'b0001111, 6, 1'b0);
        // way select follows each request
        cyc(1'b1, 7'h2A, 20'h12345, 2'b01, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 7'h0, 20'h0, 2'b10, 1'b1, 32'h1000 + 32'(i));
        cyc(1'b1, 7'h3C, 20'h54321, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 7'h0, 20'h0, 2'b01, 1'b1, 32'h2000 + 32'(i));
        for (int r = 0; r < 30; r++) refill_random(30 + 20 * (r % 4));
        cyc(1'b0, 7'h0, 20'h0, 2'b00, 1'b0, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
